// File: rtl/islip_pkg.sv
// Shared types and helpers for the iterative iSLIP switch allocator.
package islip_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ITER,
    DONE
  } state_t;

  // Pointer width for an N-entry round-robin ring; never zero so N=1 still elaborates.
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int clamp_iters(input int cfg, input int max_iters);
    if (cfg == 0) return 1;
    if (cfg > max_iters) return max_iters;
    return cfg;
  endfunction

endpackage

// File: rtl/islip_iter_allocator_rr_pick.sv
// Combinational rotate-priority picker: first set bit of vec at or after ptr, cyclically.
module rr_pick
  import islip_pkg::*;
#(
  parameter int N = 4,
  localparam int PW = ptr_width(N)
) (
  input  logic [N-1:0]  vec,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  pick,
  output logic          found
);

  logic [PW-1:0] idx;

  always_comb begin
    pick  = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < N; k++) begin
      idx = PW'((int'(ptr) + k) % N);
      if (!found && vec[idx]) begin
        pick[idx] = 1'b1;
        found     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/islip_iter_allocator.sv
// Multi-iteration iSLIP allocator: one grant/accept iteration per clock with early exit;
// round-robin pointers advance only on first-iteration accepts.
module islip_iter_allocator
  import islip_pkg::*;
#(
  parameter int NUM_IN    = 60,
  parameter int NUM_OUT   = 60,
  parameter int MAX_ITERS = 4,
  localparam int ITW      = $clog2(MAX_ITERS + 1)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             req_valid,
  output logic                             req_ready,
  input  logic [NUM_IN-1:0][NUM_OUT-1:0]   req,
  input  logic [ITW-1:0]                   iters_cfg,
  output logic                             gnt_valid,
  output logic [NUM_IN-1:0][NUM_OUT-1:0]   gnt,
  output logic [ITW-1:0]                   iters_used
);

  localparam int IPW = ptr_width(NUM_IN);
  localparam int OPW = ptr_width(NUM_OUT);

  typedef logic [IPW-1:0] in_ptr_t;
  typedef logic [OPW-1:0] out_ptr_t;

  state_t state, state_nxt;

  logic [NUM_IN-1:0][NUM_OUT-1:0] req_q;
  logic [NUM_OUT-1:0][NUM_IN-1:0] grant_vec, grant_pick;
  logic [NUM_IN-1:0][NUM_OUT-1:0] acc_vec, acc_pick;
  logic [NUM_OUT-1:0]             grant_found, out_new;
  logic [NUM_IN-1:0]              acc_found;
  logic [NUM_IN-1:0]              in_matched, in_matched_nxt;
  logic [NUM_OUT-1:0]             out_matched, out_matched_nxt;
  logic [ITW-1:0]                 iter_cnt, iter_nxt, iters_lim;
  in_ptr_t                        g_ptr [NUM_OUT];
  out_ptr_t                       a_ptr [NUM_IN];
  logic                           accept, iter_exit;

  // Outputs see only requests between still-unmatched pairs; the accept side sees the grants transposed.
  always_comb begin
    grant_vec = '0;
    acc_vec   = '0;
    for (int o = 0; o < NUM_OUT; o++) begin
      for (int i = 0; i < NUM_IN; i++) begin
        grant_vec[o][i] = req_q[i][o] & ~in_matched[i] & ~out_matched[o];
        acc_vec[i][o]   = grant_pick[o][i];
      end
    end
  end

  for (genvar o = 0; o < NUM_OUT; o++) begin : g_grant
    rr_pick #(.N(NUM_IN)) u_pick (
      .vec   (grant_vec[o]),
      .ptr   (g_ptr[o]),
      .pick  (grant_pick[o]),
      .found (grant_found[o])
    );
  end

  for (genvar i = 0; i < NUM_IN; i++) begin : g_accept
    rr_pick #(.N(NUM_OUT)) u_pick (
      .vec   (acc_vec[i]),
      .ptr   (a_ptr[i]),
      .pick  (acc_pick[i]),
      .found (acc_found[i])
    );
  end

  always_comb begin
    out_new = '0;
    for (int i = 0; i < NUM_IN; i++) out_new = out_new | acc_pick[i];
  end

  assign in_matched_nxt  = in_matched | acc_found;
  assign out_matched_nxt = out_matched | out_new;
  assign iter_nxt        = iter_cnt + ITW'(1);
  assign iter_exit       = (iter_nxt == iters_lim) || (acc_found == '0) ||
                           (&in_matched_nxt) || (&out_matched_nxt);
  assign accept          = req_valid && req_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    gnt_valid = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = ITER;
      end
      ITER: if (iter_exit) state_nxt = DONE;
      DONE: begin
        gnt_valid = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_q       <= '0;
      gnt         <= '0;
      in_matched  <= '0;
      out_matched <= '0;
      iter_cnt    <= '0;
      iters_lim   <= '0;
      iters_used  <= '0;
      for (int o = 0; o < NUM_OUT; o++) g_ptr[o] <= '0;
      for (int i = 0; i < NUM_IN; i++)  a_ptr[i] <= '0;
    end else if (accept) begin
      req_q       <= req;
      gnt         <= '0;
      in_matched  <= '0;
      out_matched <= '0;
      iter_cnt    <= '0;
      iters_lim   <= ITW'(clamp_iters(int'(iters_cfg), MAX_ITERS));
    end else if (state == ITER) begin
      gnt         <= gnt | acc_pick;
      in_matched  <= in_matched_nxt;
      out_matched <= out_matched_nxt;
      iter_cnt    <= iter_nxt;
      if (iter_exit) iters_used <= iter_nxt;
      // Pointers move only on first-iteration accepts, which is what keeps iSLIP starvation-free.
      if (iter_cnt == '0) begin
        for (int i = 0; i < NUM_IN; i++) begin
          for (int o = 0; o < NUM_OUT; o++) begin
            if (acc_pick[i][o]) begin
              g_ptr[o] <= IPW'((i + 1) % NUM_IN);
              a_ptr[i] <= OPW'((o + 1) % NUM_OUT);
            end
          end
        end
      end
    end
  end

`ifndef SYNTHESIS
  logic                gnt_ok;
  logic [NUM_IN-1:0]   gnt_col;

  always_comb begin
    gnt_ok  = ((gnt & ~req_q) == '0) && ((out_new & ~grant_found) == '0);
    gnt_col = '0;
    for (int i = 0; i < NUM_IN; i++) if (!$onehot0(gnt[i])) gnt_ok = 1'b0;
    for (int o = 0; o < NUM_OUT; o++) begin
      for (int i = 0; i < NUM_IN; i++) gnt_col[i] = gnt[i][o];
      if (!$onehot0(gnt_col)) gnt_ok = 1'b0;
    end
  end

  assert property (@(posedge clk) disable iff (rst) gnt_ok);
`endif

endmodule

// File: tb/tb_islip_iter_allocator.sv
// Randomised and directed bench for islip_iter_allocator (4x4, 4 iterations) against an iSLIP reference model.
module tb_islip_iter_allocator;

  localparam int NI  = 4;
  localparam int NO  = 4;
  localparam int MI  = 4;
  localparam int ITW = 3;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic                   req_valid = 1'b0;
  logic                   req_ready;
  logic [NI-1:0][NO-1:0]  req = '0;
  logic [ITW-1:0]         iters_cfg = '0;
  logic                   gnt_valid;
  logic [NI-1:0][NO-1:0]  gnt;
  logic [ITW-1:0]         iters_used;

  int n_checks = 0;
  int n_fail   = 0;
  int m_gp [NO];
  int m_ap [NI];

  islip_iter_allocator #(.NUM_IN(NI), .NUM_OUT(NO), .MAX_ITERS(MI)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req        (req),
    .iters_cfg  (iters_cfg),
    .gnt_valid  (gnt_valid),
    .gnt        (gnt),
    .iters_used (iters_used)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic model_reset();
    for (int o = 0; o < NO; o++) m_gp[o] = 0;
    for (int i = 0; i < NI; i++) m_ap[i] = 0;
  endtask

  // Reference iSLIP allocation on integer pointers; updates model pointers like the hardware should.
  task automatic model_alloc(input logic [NI-1:0][NO-1:0] r, input int cfg,
                             output logic [NI-1:0][NO-1:0] g, output int n);
    int lim, new_cnt, in_cnt, out_cnt;
    int gr [NO];
    bit im [NI];
    bit om [NO];
    lim = (cfg == 0) ? 1 : ((cfg > MI) ? MI : cfg);
    g = '0; n = 0; in_cnt = 0; out_cnt = 0;
    for (int i = 0; i < NI; i++) im[i] = 1'b0;
    for (int o = 0; o < NO; o++) om[o] = 1'b0;
    for (int it = 0; it < lim; it++) begin
      for (int o = 0; o < NO; o++) begin
        gr[o] = -1;
        if (!om[o]) begin
          for (int k = 0; k < NI; k++) begin
            int cand;
            cand = (m_gp[o] + k) % NI;
            if (gr[o] < 0 && !im[cand] && r[cand][o]) gr[o] = cand;
          end
        end
      end
      new_cnt = 0;
      for (int i = 0; i < NI; i++) begin
        int best;
        best = -1;
        if (!im[i]) begin
          for (int k = 0; k < NO; k++) begin
            int oc;
            oc = (m_ap[i] + k) % NO;
            if (best < 0 && gr[oc] == i) best = oc;
          end
        end
        if (best >= 0) begin
          g[i][best] = 1'b1;
          im[i] = 1'b1; om[best] = 1'b1;
          new_cnt++; in_cnt++; out_cnt++;
          if (it == 0) begin
            m_gp[best] = (i + 1) % NI;
            m_ap[i]    = (best + 1) % NO;
          end
        end
      end
      n = it + 1;
      if (new_cnt == 0 || in_cnt == NI || out_cnt == NO) break;
    end
  endtask

  // Drives one request; with hold set, req_valid stays high and req/iters_cfg are scrambled while busy.
  task automatic run_alloc(input logic [NI-1:0][NO-1:0] r, input logic [ITW-1:0] cfg, input bit hold,
                           output logic [NI-1:0][NO-1:0] g, output int n, output int cyc, output bit rdy);
    rdy = 1'b1;
    @(negedge clk);
    if (req_ready !== 1'b1) rdy = 1'b0;
    req_valid = 1'b1;
    req       = r;
    iters_cfg = cfg;
    @(negedge clk);
    cyc = 1;
    if (!hold) req_valid = 1'b0;
    while (gnt_valid !== 1'b1 && cyc < 20) begin
      if (req_ready !== 1'b0) rdy = 1'b0;
      if (hold) begin
        req       = 16'($urandom);
        iters_cfg = 3'($urandom_range(0, 7));
      end
      @(negedge clk);
      cyc++;
    end
    if (req_ready !== 1'b0) rdy = 1'b0;
    g = gnt;
    n = int'(iters_used);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL reset.req_ready got %b want 1", req_ready); end
    n_checks++; if (gnt_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset.gnt_valid got %b want 0", gnt_valid); end
    n_checks++; if (gnt !== 16'h0) begin n_fail++; $display("[TB] FAIL reset.gnt got %h want 0000", gnt); end
    n_checks++; if (iters_used !== 3'd0) begin n_fail++; $display("[TB] FAIL reset.iters_used got %0d want 0", iters_used); end
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_pointer_desync();
    logic [NI-1:0][NO-1:0] g, eg;
    int n, en, cyc;
    bit rdy;
    run_alloc(16'hFFFF, 3'd1, 1'b0, g, n, cyc, rdy);
    model_alloc(16'hFFFF, 1, eg, en);
    n_checks++; if (g !== 16'h0001) begin n_fail++; $display("[TB] FAIL desync1.gnt got %h want 0001", g); end
    n_checks++; if (g !== eg) begin n_fail++; $display("[TB] FAIL desync1.model got %h want %h", g, eg); end
    n_checks++; if (n !== 1) begin n_fail++; $display("[TB] FAIL desync1.iters_used got %0d want 1", n); end
    n_checks++; if (cyc !== 2) begin n_fail++; $display("[TB] FAIL desync1.latency got %0d want 2", cyc); end
    n_checks++; if (rdy !== 1'b1) begin n_fail++; $display("[TB] FAIL desync1.req_ready got bad want ok"); end
    @(negedge clk);
    n_checks++; if (gnt_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL desync1.pulse got %b want 0", gnt_valid); end
    n_checks++; if (gnt !== g) begin n_fail++; $display("[TB] FAIL desync1.stable got %h want %h", gnt, g); end
    run_alloc(16'hFFFF, 3'd1, 1'b0, g, n, cyc, rdy);
    model_alloc(16'hFFFF, 1, eg, en);
    n_checks++; if (g !== 16'h0012) begin n_fail++; $display("[TB] FAIL desync2.gnt got %h want 0012", g); end
    n_checks++; if (g !== eg) begin n_fail++; $display("[TB] FAIL desync2.model got %h want %h", g, eg); end
  endtask

  task automatic test_identity();
    logic [NI-1:0][NO-1:0] g, eg;
    int n, en, cyc;
    bit rdy;
    run_alloc(16'hFFFF, 3'd4, 1'b0, g, n, cyc, rdy);
    model_alloc(16'hFFFF, 4, eg, en);
    n_checks++; if (g !== 16'h8421) begin n_fail++; $display("[TB] FAIL identity.gnt got %h want 8421", g); end
    n_checks++; if (g !== eg) begin n_fail++; $display("[TB] FAIL identity.model got %h want %h", g, eg); end
    n_checks++; if (n !== 4) begin n_fail++; $display("[TB] FAIL identity.iters_used got %0d want 4", n); end
    n_checks++; if (cyc !== 5) begin n_fail++; $display("[TB] FAIL identity.latency got %0d want 5", cyc); end
    run_alloc(16'hFFFF, 3'd1, 1'b0, g, n, cyc, rdy);
    model_alloc(16'hFFFF, 1, eg, en);
    n_checks++; if (g !== 16'h0012) begin n_fail++; $display("[TB] FAIL identity.ptrs got %h want 0012", g); end
    n_checks++; if (g !== eg) begin n_fail++; $display("[TB] FAIL identity.ptrs_model got %h want %h", g, eg); end
  endtask

  task automatic test_early_stop();
    logic [NI-1:0][NO-1:0] g, eg;
    int n, en, cyc;
    bit rdy;
    run_alloc(16'h0001, 3'd4, 1'b0, g, n, cyc, rdy);
    model_alloc(16'h0001, 4, eg, en);
    n_checks++; if (g !== 16'h0001) begin n_fail++; $display("[TB] FAIL early.gnt got %h want 0001", g); end
    n_checks++; if (n !== 2) begin n_fail++; $display("[TB] FAIL early.iters_used got %0d want 2", n); end
    n_checks++; if (cyc !== 3) begin n_fail++; $display("[TB] FAIL early.latency got %0d want 3", cyc); end
    run_alloc(16'h0000, 3'd4, 1'b0, g, n, cyc, rdy);
    model_alloc(16'h0000, 4, eg, en);
    n_checks++; if (g !== 16'h0000) begin n_fail++; $display("[TB] FAIL zero.gnt got %h want 0000", g); end
    n_checks++; if (n !== 1) begin n_fail++; $display("[TB] FAIL zero.iters_used got %0d want 1", n); end
    run_alloc(16'hFFFF, 3'd1, 1'b0, g, n, cyc, rdy);
    model_alloc(16'hFFFF, 1, eg, en);
    n_checks++; if (g !== eg) begin n_fail++; $display("[TB] FAIL zero.ptrs got %h want %h", g, eg); end
  endtask

  task automatic test_cfg_clamp();
    logic [NI-1:0][NO-1:0] g, eg;
    int n, en, cyc;
    bit rdy;
    run_alloc(16'hFFFF, 3'd0, 1'b0, g, n, cyc, rdy);
    model_alloc(16'hFFFF, 0, eg, en);
    n_checks++; if (n !== 1) begin n_fail++; $display("[TB] FAIL cfg0.iters_used got %0d want 1", n); end
    n_checks++; if (g !== eg) begin n_fail++; $display("[TB] FAIL cfg0.gnt got %h want %h", g, eg); end
    run_alloc(16'hFFFF, 3'd7, 1'b0, g, n, cyc, rdy);
    model_alloc(16'hFFFF, 7, eg, en);
    n_checks++; if (n > 4 || n !== en) begin n_fail++; $display("[TB] FAIL cfg7.iters_used got %0d want %0d", n, en); end
    n_checks++; if (g !== eg) begin n_fail++; $display("[TB] FAIL cfg7.gnt got %h want %h", g, eg); end
    n_checks++; if (cyc !== en + 1) begin n_fail++; $display("[TB] FAIL cfg7.latency got %0d want %0d", cyc, en + 1); end
  endtask

  task automatic test_back_to_back();
    logic [NI-1:0][NO-1:0] g, eg, r1, r2;
    int n, en, cyc;
    bit rdy;
    r1 = 16'($urandom) | 16'h0421;
    run_alloc(r1, 3'd4, 1'b1, g, n, cyc, rdy);
    model_alloc(r1, 4, eg, en);
    n_checks++; if (g !== eg) begin n_fail++; $display("[TB] FAIL hold.gnt got %h want %h", g, eg); end
    n_checks++; if (n !== en) begin n_fail++; $display("[TB] FAIL hold.iters_used got %0d want %0d", n, en); end
    n_checks++; if (rdy !== 1'b1) begin n_fail++; $display("[TB] FAIL hold.req_ready got high-while-busy want low"); end
    @(negedge clk);
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL hold.idle_ready got %b want 1", req_ready); end
    r2 = 16'($urandom);
    req = r2;
    iters_cfg = 3'd2;
    @(negedge clk);
    n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL hold.accept got %b want 0", req_ready); end
    req_valid = 1'b0;
    cyc = 1;
    while (gnt_valid !== 1'b1 && cyc < 20) begin @(negedge clk); cyc++; end
    model_alloc(r2, 2, eg, en);
    n_checks++; if (gnt !== eg) begin n_fail++; $display("[TB] FAIL hold.next_gnt got %h want %h", gnt, eg); end
    n_checks++; if (cyc !== en + 1) begin n_fail++; $display("[TB] FAIL hold.next_latency got %0d want %0d", cyc, en + 1); end
  endtask

  task automatic test_random();
    logic [NI-1:0][NO-1:0] g, eg, r;
    logic [ITW-1:0] cfg;
    int n, en, cyc;
    bit rdy;
    for (int t = 0; t < 40; t++) begin
      case ($urandom_range(0, 2))
        0:       r = 16'($urandom);
        1:       r = 16'($urandom) & 16'($urandom);
        default: r = 16'($urandom) | 16'($urandom);
      endcase
      cfg = 3'($urandom_range(0, 7));
      run_alloc(r, cfg, 1'b0, g, n, cyc, rdy);
      model_alloc(r, int'(cfg), eg, en);
      n_checks++; if (g !== eg) begin n_fail++; $display("[TB] FAIL rand%0d.gnt got %h want %h (req %h cfg %0d)", t, g, eg, r, cfg); end
      n_checks++; if (n !== en) begin n_fail++; $display("[TB] FAIL rand%0d.iters_used got %0d want %0d", t, n, en); end
      n_checks++; if (cyc !== en + 1) begin n_fail++; $display("[TB] FAIL rand%0d.latency got %0d want %0d", t, cyc, en + 1); end
      n_checks++; if (rdy !== 1'b1) begin n_fail++; $display("[TB] FAIL rand%0d.req_ready got bad want ok", t); end
      @(negedge clk);
      n_checks++; if (gnt_valid !== 1'b0 || gnt !== g) begin n_fail++; $display("[TB] FAIL rand%0d.hold got v=%b %h want v=0 %h", t, gnt_valid, gnt, g); end
    end
  endtask

  task automatic test_reset_mid();
    logic [NI-1:0][NO-1:0] g, eg;
    int n, en, cyc;
    bit rdy;
    test_reset();
    @(negedge clk);
    req_valid = 1'b1;
    req = 16'hFFFF;
    iters_cfg = 3'd4;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (gnt !== 16'h0001) begin n_fail++; $display("[TB] FAIL midrst.partial got %h want 0001", gnt); end
    #1 rst = 1'b1;
    #1;
    n_checks++; if (gnt !== 16'h0) begin n_fail++; $display("[TB] FAIL midrst.gnt got %h want 0000", gnt); end
    n_checks++; if (gnt_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL midrst.gnt_valid got %b want 0", gnt_valid); end
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL midrst.req_ready got %b want 1", req_ready); end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    run_alloc(16'hFFFF, 3'd1, 1'b0, g, n, cyc, rdy);
    model_alloc(16'hFFFF, 1, eg, en);
    n_checks++; if (g !== 16'h0001) begin n_fail++; $display("[TB] FAIL midrst.after got %h want 0001", g); end
    n_checks++; if (g !== eg) begin n_fail++; $display("[TB] FAIL midrst.model got %h want %h", g, eg); end
  endtask

  initial begin
    test_reset();
    test_pointer_desync();
    test_reset();
    test_identity();
    test_early_stop();
    test_cfg_clamp();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
